// File: rtl/pwm_servo_driver.sv
// Sign-magnitude PWM driver for an H-bridge: signed controller word in, pwm/in1/in2 out.
// Latency: a sample captured by en reaches the outputs at the next period wrap; all outputs registered.
// Backpressure: none; en is a one-cycle strobe and is never stalled.
`timescale 1ns/1ps
module pwm_servo_driver #(
    parameter int cant_bits = 13,
    parameter int PWM_BITS  = 10,
    parameter int DEAD      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic signed [cant_bits-1:0] salida,
    output logic                        pwm,
    output logic                        in1,
    output logic                        in2,
    output logic                        period_end
);

    localparam int MAG_BITS = cant_bits - 1;

    localparam logic [PWM_BITS-1:0] CNT_MAX   = '1;
    localparam logic [PWM_BITS-1:0] CNT_ARM   = PWM_BITS'((2 ** PWM_BITS) - 2);
    localparam logic [PWM_BITS-1:0] DEAD_LAST = PWM_BITS'(DEAD - 1);

    typedef enum logic [1:0] {
        ST_COAST = 2'd0,
        ST_FWD   = 2'd1,
        ST_REV   = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    state_t                        target;
    state_t                        target_now;

    logic [PWM_BITS-1:0]           cnt;
    logic signed [cant_bits-1:0]   shadow;
    logic [MAG_BITS-1:0]           mag;
    logic [PWM_BITS-1:0]           duty;
    logic [PWM_BITS-1:0]           active_duty;
    logic                          wrap;
    logic                          dead_done;
    logic                          pwm_nxt;
    logic                          in1_nxt;
    logic                          in2_nxt;

    assign wrap      = (cnt == CNT_MAX);
    assign dead_done = (cnt == DEAD_LAST);

    // |u| in MAG_BITS; the most negative code has no positive twin and saturates to all ones.
    always_comb begin
        mag = shadow[MAG_BITS-1:0];
        if (shadow[cant_bits-1]) begin
            if (shadow[MAG_BITS-1:0] == '0) begin
                mag = '1;
            end else begin
                mag = ~shadow[MAG_BITS-1:0] + 1'b1;
            end
        end
    end

    assign duty = mag[MAG_BITS-1 -: PWM_BITS];

    always_comb begin
        target_now = ST_COAST;
        if (shadow[cant_bits-1]) begin
            target_now = ST_REV;
        end else if (shadow != '0) begin
            target_now = ST_FWD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_COAST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_COAST: begin
                if (wrap) state_nxt = target_now;
            end
            ST_FWD: begin
                if (wrap) state_nxt = (target_now == ST_REV) ? ST_DEAD : target_now;
            end
            ST_REV: begin
                if (wrap) state_nxt = (target_now == ST_FWD) ? ST_DEAD : target_now;
            end
            ST_DEAD: begin
                if (dead_done) state_nxt = target;
            end
            default: state_nxt = ST_COAST;
        endcase

        // Leg selects follow the state they will sit in; pwm lags the current state by a cycle,
        // so a leg is always selected before its pwm can rise and released no later than pwm falls.
        in1_nxt = (state_nxt == ST_FWD);
        in2_nxt = (state_nxt == ST_REV);
        pwm_nxt = ((state == ST_FWD) || (state == ST_REV)) && (cnt < active_duty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            shadow      <= '0;
            active_duty <= '0;
            target      <= ST_COAST;
            pwm         <= 1'b0;
            in1         <= 1'b0;
            in2         <= 1'b0;
            period_end  <= 1'b0;
        end else begin
            cnt        <= cnt + 1'b1;
            pwm        <= pwm_nxt;
            in1        <= in1_nxt;
            in2        <= in2_nxt;
            period_end <= (cnt == CNT_ARM);
            if (en) begin
                shadow <= salida;
            end
            // Duty and direction use the shadow value from before this edge.
            if (wrap) begin
                active_duty <= duty;
                target      <= target_now;
            end
        end
    end

endmodule

// File: tb/tb_pwm_servo_driver.sv
// Randomized and directed bench for pwm_servo_driver against a per-period reference model.
`timescale 1ns/1ps
module tb_pwm_servo_driver;

    localparam int CB    = 13;
    localparam int PB    = 10;
    localparam int DT    = 16;
    localparam int PER   = 1 << PB;
    localparam int SHIFT = CB - 1 - PB;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic signed [CB-1:0] salida = '0;
    logic                 pwm;
    logic                 in1;
    logic                 in2;
    logic                 period_end;

    pwm_servo_driver #(.cant_bits(CB), .PWM_BITS(PB), .DEAD(DT)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .salida     (salida),
        .pwm        (pwm),
        .in1        (in1),
        .in2        (in2),
        .period_end (period_end)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: offset within period, shadow value, per-period expectation.
    int o;
    int m_shadow;
    int next_val;
    int cur_target;   // 0 coast, 1 fwd, 2 rev
    int cur_swap;
    int cur_duty;
    int cur_exp_hi;
    int pnum;
    int hi_cnt, pwm_err, in1_err, in2_err, both_cnt, pe_err;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_period(input int v);
        int prev;
        int mag;
        int tgt;
        prev = cur_target;
        tgt  = (v > 0) ? 1 : ((v < 0) ? 2 : 0);
        if (v < 0) mag = (v == -(1 << (CB - 1))) ? (1 << (CB - 1)) - 1 : -v;
        else       mag = v;
        cur_duty   = mag >> SHIFT;
        cur_swap   = ((prev == 1 && tgt == 2) || (prev == 2 && tgt == 1)) ? 1 : 0;
        cur_target = tgt;
        if (tgt == 0)      cur_exp_hi = 0;
        else if (cur_swap) cur_exp_hi = (cur_duty > DT) ? cur_duty - DT : 0;
        else               cur_exp_hi = cur_duty;
        hi_cnt = 0; pwm_err = 0; in1_err = 0; in2_err = 0; both_cnt = 0; pe_err = 0;
    endtask

    task automatic close_period();
        check($sformatf("p%0d_pwm_high", pnum), hi_cnt, cur_exp_hi);
        check($sformatf("p%0d_pwm_shape", pnum), pwm_err, 0);
        check($sformatf("p%0d_in1", pnum), in1_err, 0);
        check($sformatf("p%0d_in2", pnum), in2_err, 0);
        check($sformatf("p%0d_in_overlap", pnum), both_cnt, 0);
        check($sformatf("p%0d_period_end", pnum), pe_err, 0);
        pnum++;
    endtask

    task automatic reset_model();
        cur_target = 0;
        m_shadow   = 0;
        o          = 0;
        start_period(0);
    endtask

    // One clock cycle: drive, sample at negedge, score, then cross the edge.
    task automatic cycle(input bit en_i, input int val_i);
        int  dm;
        int  start;
        bit  e_pwm;
        en     = en_i;
        salida = CB'(val_i);
        @(negedge clk);
        dm    = (cur_swap != 0 && o < DT) ? 0 : cur_target;
        start = (cur_swap != 0) ? DT + 1 : 1;
        e_pwm = (dm != 0) && (o >= start) && (o <= cur_duty);
        if (pwm !== e_pwm) pwm_err++;
        if (pwm === 1'b1) hi_cnt++;
        if (in1 !== (dm == 1)) in1_err++;
        if (in2 !== (dm == 2)) in2_err++;
        if (in1 === 1'b1 && in2 === 1'b1) both_cnt++;
        if (period_end !== (o == PER - 1)) pe_err++;
        if (o == PER - 1) next_val = m_shadow;
        if (en_i) m_shadow = val_i;
        @(posedge clk);
        #1;
        en = 1'b0;
        o++;
        if (o == PER) begin
            close_period();
            o = 0;
            start_period(next_val);
        end
    endtask

    task automatic run_to(input int off);
        int guard;
        guard = 0;
        while (o != off && guard < 2 * PER) begin
            cycle(1'b0, 0);
            guard++;
        end
    endtask

    task automatic run_period();
        for (int k = 0; k < PER; k++) cycle(1'b0, 0);
    endtask

    task automatic do_reset(input int n, input bit en_i, input int val_i);
        rst    = 1'b1;
        en     = en_i;
        salida = CB'(val_i);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("rst_pwm", int'(pwm), 0);
            check("rst_in1", int'(in1), 0);
            check("rst_in2", int'(in2), 0);
            check("rst_period_end", int'(period_end), 0);
        end
        rst = 1'b0;
        en  = 1'b0;
        reset_model();
    endtask

    function automatic int pick();
        int v;
        case ($urandom_range(0, 5))
            0:       v = -4096;
            1:       v = 4095;
            2:       v = 0;
            3:       v = int'($urandom_range(1, 80));
            4:       v = -int'($urandom_range(1, 80));
            default: v = int'($urandom_range(0, 8191)) - 4096;
        endcase
        return v;
    endfunction

    initial begin
        #(950_000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        pnum       = 0;
        cur_target = 0;
        do_reset(3, 1'b1, 500);

        run_to(10); cycle(1'b1, 2000); run_to(0);
        repeat (3) run_period();

        run_to(5); cycle(1'b1, -4096); run_to(0);
        run_period();
        run_to(5); cycle(1'b1, -1); run_to(0);

        run_to(5); cycle(1'b1, 400); run_to(0);
        run_to(5); cycle(1'b1, -400); run_to(0);
        run_period();

        run_to(5); cycle(1'b1, 0); run_to(0);
        run_to(PER - 1); cycle(1'b1, 800);
        run_period();

        run_to(5); cycle(1'b1, 2000); run_to(0);
        run_to(300);
        do_reset(3, 1'b1, 500);
        cycle(1'b1, 0); run_to(0);
        run_period();

        for (int p = 0; p < 14; p++) begin
            int eo;
            int v;
            bit doit;
            eo   = ($urandom_range(0, 3) == 0) ? PER - 1 : int'($urandom_range(0, PER - 1));
            v    = pick();
            doit = ($urandom_range(0, 4) != 0);
            for (int k = 0; k < PER; k++) cycle(doit && (o == eo), v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
